// File: rtl/enc_pkg.sv
// Shared types and constants for the 5x5 matrix encoder: line geometry, controller
// states and the coordinate permutation applied once per round.
package enc_pkg;

    localparam int unsigned LINE_W = 25;
    localparam int unsigned DIM    = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_OUT   = 2'd2
    } state_e;

    // Destination bit index for source bit i; bit i sits at cell x=i%5, y=i/5.
    function automatic int unsigned perm_idx(input int unsigned i);
        int unsigned x;
        int unsigned y;
        int unsigned nx;
        int unsigned ny;
        x  = (i % DIM + 3) % DIM;
        y  = (i / DIM + 3) % DIM;
        nx = (y + 2) % DIM;
        ny = (2 * x + 3 * y + 2) % DIM;
        return ny * DIM + nx;
    endfunction

endpackage

// File: rtl/matrix_permute.sv
// One round of the 5x5 coordinate permutation; pure wiring, every input bit lands
// on exactly one output bit.
module matrix_permute
    import enc_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o
);

    for (genvar i = 0; i < int'(LINE_W); i++) begin : g_bit
        assign line_o[perm_idx(i)] = line_i[i];
    end

endmodule

// File: rtl/encoder_round_ctrl.sv
// Round sequencer for the matrix encoder: accepts a line, permutes it ROUNDS times
// in place, then offers it downstream while counting lines per frame.
module encoder_round_ctrl
    import enc_pkg::*;
#(
    parameter int unsigned N         = 25,
    parameter int unsigned ROUNDS    = 1,
    parameter int unsigned NUM_LINES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_line,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_line,
    output logic         wr_en,
    output logic         busy,
    output logic [7:0]   round_idx,
    output logic         frame_done
);

    localparam int unsigned     CntW      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [CntW-1:0] LastLine  = CntW'(NUM_LINES - 1);
    localparam logic [7:0]      RoundsL   = 8'(ROUNDS);
    localparam logic [7:0]      LastRound = 8'((ROUNDS == 0) ? 32'd0 : ROUNDS - 1);
    localparam state_e          LoadState = (ROUNDS == 0) ? S_OUT : S_ROUND;

    state_e          state_q, state_d;
    logic [N-1:0]    line_q, line_d;
    logic [N-1:0]    perm_line;
    logic [7:0]      round_q, round_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_hs;

    matrix_permute u_permute (
        .line_i (line_q),
        .line_o (perm_line)
    );

    assign out_hs = (state_q == S_OUT) & out_ready;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    line_d  = in_line;
                    round_d = 8'd0;
                    state_d = LoadState;
                end
            end
            S_ROUND: begin
                line_d  = perm_line;
                round_d = round_q + 8'd1;
                if (round_q == LastRound) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    cnt_d = (cnt_q == LastLine) ? '0 : cnt_q + 1'b1;
                    // A waiting line is taken in the same cycle to avoid a bubble.
                    if (in_valid) begin
                        line_d  = in_line;
                        round_d = 8'd0;
                        state_d = LoadState;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            round_q <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
        end
    end

    // in_ready follows out_ready combinationally while a result is on offer.
    assign in_ready   = (state_q == S_IDLE) | out_hs;
    assign out_valid  = (state_q == S_OUT);
    assign out_line   = line_q;
    assign wr_en      = out_hs;
    assign frame_done = out_hs & (cnt_q == LastLine);
    assign busy       = (state_q == S_ROUND) | (state_q == S_OUT);
    assign round_idx  = round_q;

    a_out_hold: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_line)));

    a_round_sat: assert property (@(posedge clk) disable iff (!rst)
        round_idx <= RoundsL);

endmodule

// File: tb/tb_encoder_round_ctrl.sv
// Bench for encoder_round_ctrl: four configurations share one stimulus stream and are
// checked every cycle against a transaction-level model, plus directed sequences.
module tb_encoder_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        out_ready;
    logic [24:0] in_line;
    logic [3:0]  in_ready, out_valid, wr_en, busy, frame_done;
    logic [24:0] out_line  [4];
    logic [7:0]  round_idx [4];

    always #5 clk = ~clk;

    encoder_round_ctrl #(.N(25), .ROUNDS(1), .NUM_LINES(64)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_line(in_line), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_line(out_line[0]), .wr_en(wr_en[0]), .busy(busy[0]),
        .round_idx(round_idx[0]), .frame_done(frame_done[0]));
    encoder_round_ctrl #(.N(25), .ROUNDS(2), .NUM_LINES(64)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_line(in_line), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_line(out_line[1]), .wr_en(wr_en[1]), .busy(busy[1]),
        .round_idx(round_idx[1]), .frame_done(frame_done[1]));
    encoder_round_ctrl #(.N(25), .ROUNDS(4), .NUM_LINES(3)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_line(in_line), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_line(out_line[2]), .wr_en(wr_en[2]), .busy(busy[2]),
        .round_idx(round_idx[2]), .frame_done(frame_done[2]));
    encoder_round_ctrl #(.N(25), .ROUNDS(0), .NUM_LINES(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
        .in_line(in_line), .out_valid(out_valid[3]), .out_ready(out_ready),
        .out_line(out_line[3]), .wr_en(wr_en[3]), .busy(busy[3]),
        .round_idx(round_idx[3]), .frame_done(frame_done[3]));

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input int d, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
        end
    endfunction

    function automatic int rounds_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int nlines_of(input int d);
        case (d)
            2:       return 3;
            3:       return 1;
            default: return 64;
        endcase
    endfunction

    // Permutation straight from the coordinate rules.
    function automatic logic [24:0] perm_once(input logic [24:0] s);
        logic [24:0] o;
        int x, y, nx, ny;
        o = '0;
        for (int i = 0; i < 25; i++) begin
            x  = (i % 5 + 3) % 5;
            y  = (i / 5 + 3) % 5;
            nx = (y + 2) % 5;
            ny = (2 * x + 3 * y + 2) % 5;
            o[ny * 5 + nx] = s[i];
        end
        return o;
    endfunction

    function automatic logic [24:0] perm_n(input logic [24:0] s, input int r);
        logic [24:0] v;
        v = s;
        for (int k = 0; k < r; k++) v = perm_once(v);
        return v;
    endfunction

    // Transaction model: a line accepted at cycle acc is offered from cycle acc+ROUNDS.
    bit          have      [4];
    int          acc       [4];
    logic [24:0] exp_line  [4];
    int          cnt       [4];
    int          ridx_idle [4];
    int          cyc   = 0;
    bit          chk_en = 1'b0;

    function automatic bit m_out(input int d);
        return have[d] && (cyc - acc[d] >= rounds_of(d));
    endfunction

    function automatic bit m_rdy(input int d);
        return !have[d] || (m_out(d) && out_ready);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                have[d]      <= 1'b0;
                cnt[d]       <= 0;
                ridx_idle[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (m_out(d) && out_ready) begin
                    cnt[d]       <= (cnt[d] + 1) % nlines_of(d);
                    have[d]      <= 1'b0;
                    ridx_idle[d] <= rounds_of(d);
                end
                if (in_valid && m_rdy(d)) begin
                    have[d]     <= 1'b1;
                    acc[d]      <= cyc + 1;
                    exp_line[d] <= perm_n(in_line, rounds_of(d));
                end
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 4; d++) begin
                check("in_ready", d, in_ready[d], m_rdy(d));
                check("out_valid", d, out_valid[d], m_out(d));
                check("busy", d, busy[d], have[d]);
                check("wr_en", d, wr_en[d], m_out(d) && out_ready);
                check("frame_done", d, frame_done[d],
                      m_out(d) && out_ready && (cnt[d] == nlines_of(d) - 1));
                check("round_idx", d, round_idx[d],
                      !have[d] ? ridx_idle[d] :
                      (cyc - acc[d] < rounds_of(d)) ? cyc - acc[d] : rounds_of(d));
                if (m_out(d)) check("out_line", d, out_line[d], exp_line[d]);
            end
        end
    end

    // Event logs for the directed sequences.
    int          wr_cnt0 = 0;
    int          wr_cnt2 = 0;
    int          hs2     = 0;
    int          fd_q    [$];
    bit          log_en  = 1'b0;
    logic [24:0] log_line[$];
    int          log_cyc [$];

    always @(negedge clk) begin
        if (wr_en[0]) wr_cnt0 <= wr_cnt0 + 1;
        if (wr_en[2]) wr_cnt2 <= wr_cnt2 + 1;
        if (!rst) begin
            hs2 <= 0;
            fd_q.delete();
        end else if (out_valid[2] && out_ready) begin
            hs2 <= hs2 + 1;
            if (frame_done[2]) fd_q.push_back(hs2 + 1);
        end
        if (log_en && out_valid[0] && out_ready) begin
            log_line.push_back(out_line[0]);
            log_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [24:0] line;
        logic [24:0] exp_r1;
        logic [24:0] exp_r2;
    } vec_t;

    vec_t        vecs [6];
    logic [24:0] l_a, l_b, l_exp;
    logic [24:0] lines4 [4];
    int          w0, n;
    bit          got;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{25'h0000001, 25'h0000400, 25'h0020000};
        vecs[1] = '{25'h0001000, 25'h0001000, 25'h0001000};
        vecs[2] = '{25'h0000002, 25'h0100000, 25'h1000000};
        vecs[3] = '{25'h1000000, 25'h0004000, 25'h0000080};
        vecs[4] = '{25'h0001001, 25'h0001400, 25'h0021000};
        vecs[5] = '{25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_line   = '0;
        #3 rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            check("rst_in_ready", d, in_ready[d], 1);
            check("rst_out_valid", d, out_valid[d], 0);
            check("rst_busy", d, busy[d], 0);
            check("rst_wr_en", d, wr_en[d], 0);
            check("rst_frame_done", d, frame_done[d], 0);
            check("rst_round_idx", d, round_idx[d], 0);
        end
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Single line through the one-round instance.
        in_valid = 1'b1;
        in_line  = 25'h0000001;
        #2 check("t1_in_ready", 0, in_ready[0], 1);
        tick();
        in_valid = 1'b0;
        #2 check("t1_busy", 0, busy[0], 1);
        check("t1_not_valid", 0, out_valid[0], 0);
        tick();
        #2 check("t1_valid", 0, out_valid[0], 1);
        check("t1_line", 0, out_line[0], 25'h0000400);
        check("t1_round_idx", 0, round_idx[0], 1);
        w0 = wr_cnt0;
        tick();
        out_ready = 1'b1;
        #2 check("t1_wr_en", 0, wr_en[0], 1);
        tick();
        #2 check("t1_wr_once", 0, wr_cnt0 - w0, 1);
        drain();

        // Table of known permutation results.
        for (int k = 0; k < 6; k++) begin
            tick();
            in_valid  = 1'b1;
            in_line   = vecs[k].line;
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                #2;
                if (out_valid[0] && out_valid[1]) got = 1'b1;
            end
            check("tbl_timeout", k, got, 1);
            if (got) begin
                check("tbl_r1", k, out_line[0], vecs[k].exp_r1);
                check("tbl_r2", k, out_line[1], vecs[k].exp_r2);
            end
            drain();
        end

        // Back-pressure holds the result.
        l_a   = 25'($urandom);
        l_exp = perm_n(l_a, 1);
        tick();
        in_valid  = 1'b1;
        in_line   = l_a;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        w0 = wr_cnt0;
        for (int c = 0; c < 10; c++) begin
            tick();
            #2;
            check("bp_valid", 0, out_valid[0], 1);
            check("bp_in_ready", 0, in_ready[0], 0);
            check("bp_wr_en", 0, wr_en[0], 0);
            check("bp_line", 0, out_line[0], l_exp);
        end
        out_ready = 1'b1;
        tick();
        #2 check("bp_wr_once", 0, wr_cnt0 - w0, 1);
        drain();

        // Back-to-back stream, one output every two cycles in order.
        for (int k = 0; k < 4; k++) lines4[k] = 25'($urandom);
        log_en    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_line = lines4[k];
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                #2;
                if (in_ready[0]) got = 1'b1;
                tick();
            end
            check("b2b_accept", k, got, 1);
        end
        in_valid = 1'b0;
        repeat (4) tick();
        log_en = 1'b0;
        check("b2b_count", 0, log_line.size(), 4);
        for (int k = 0; k < 4 && k < log_line.size(); k++) begin
            check("b2b_line", k, log_line[k], perm_n(lines4[k], 1));
            if (k > 0) check("b2b_spacing", k, log_cyc[k] - log_cyc[k-1], 2);
        end
        drain();

        // Frame counting with three lines per frame.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 7; c++) begin
            in_line = 25'($urandom);
            #2;
            if (in_ready[2]) n++;
            tick();
        end
        check("frame_accepts", 2, n, 7);
        drain();
        check("frame_pulses", 2, fd_q.size(), 2);
        if (fd_q.size() == 2) begin
            check("frame_pos0", 2, fd_q[0], 3);
            check("frame_pos1", 2, fd_q[1], 6);
        end
        in_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            in_line = 25'($urandom);
            #2;
            if (in_ready[2]) n++;
            tick();
        end
        drain();
        check("frame_pulses_after", 2, fd_q.size(), 3);
        if (fd_q.size() == 3) check("frame_pos2", 2, fd_q[2], 9);

        // Asynchronous reset in the middle of the rounds.
        l_a = 25'($urandom);
        tick();
        in_valid  = 1'b1;
        in_line   = l_a;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        w0 = wr_cnt2;
        #5 rst = 1'b0;
        #1;
        check("mid_rst_busy", 2, busy[2], 0);
        check("mid_rst_valid", 2, out_valid[2], 0);
        check("mid_rst_in_ready", 2, in_ready[2], 1);
        check("mid_rst_round_idx", 2, round_idx[2], 0);
        check("mid_rst_wr_en", 2, wr_en[2], 0);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("mid_rst_no_wr", 2, wr_cnt2 - w0, 0);
        out_ready = 1'b0;
        l_b = 25'($urandom);
        in_valid = 1'b1;
        in_line  = l_b;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2 check("post_rst_valid", 2, out_valid[2], 1);
        check("post_rst_line", 2, out_line[2], perm_n(l_b, 4));
        check("post_rst_round_idx", 2, round_idx[2], 4);
        drain();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_line   = 25'($urandom);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
